word_byte_framer: RTL and testbench
===================================

# word_byte_framer

Downstream stage of the wide-word-to-32-bit-word serializer. Accepts its word stream (valid/last/last_bytes, no backpressure), buffers it in a synchronous FIFO, and emits an 8-bit AXI-stream-style byte stream with ready/valid backpressure. After the last data byte of each frame it appends a 4-byte CRC-32 trailer. Overflow and frame-count status go to the control/status register block.

## Interface
Parameters:
- FIFO_DEPTH, 512: word entries in the input FIFO; power of two, at least 4.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high. The clock is i_clk.
- i_data  in  32  input word; bits [31:24] are the first byte in stream order.
- i_valid  in  1  word strobe; never stalled.
- i_last  in  1  marks the final word of the frame; sampled only with i_valid.
- i_last_bytes  in  2  valid bytes minus 1 in the last word; 3 means 4 bytes. Ignored unless i_last is set.
- o_tdata  out  8  output byte.
- o_tvalid  out  1  o_tdata is valid.
- i_tready  in  1  downstream accepts the byte.
- o_tlast  out  1  set on the final CRC byte of the frame.
- o_overflow  out  1  sticky: a word was dropped because the FIFO was full.
- o_frame_cnt  out  16  count of completed frames; wraps.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Write side**
  - A word with i_valid is written as {last, nbytes-1, data}.
  - Non-last words always carry 4 bytes.
  - If the FIFO is full, the word is dropped, o_overflow sets, and the FIFO state is unchanged.
- **FSM states**
  - IDLE: wait for a non-empty FIFO, then load the word, set byte index 0, seed CRC to 0xFFFFFFFF, go to DATA.
  - DATA: emit bytes index 0 up to nbytes-1, in order [31:24], [23:16], [15:8], [7:0].
    - Each accepted byte updates the CRC.
    - After the final byte of a non-last word, pop the next word. If the FIFO is empty, deassert o_tvalid and hold in DATA until a word arrives.
    - After the final byte of a last word, go to CRC.
  - CRC: emit ~crc in 4 bytes, least-significant byte first, with o_tlast on the 4th byte.
    - On acceptance of the 4th byte, o_frame_cnt increments.
    - If the FIFO is non-empty, start the next frame immediately (reseed CRC, go to DATA). Otherwise go to IDLE.
- **CRC**
  - CRC-32 IEEE, reflected form, polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Byte-wise combinational update, 8 unrolled bit steps.
- **Handshake**
  - A transfer occurs when o_tvalid and i_tready are both high.
  - While o_tvalid is high and i_tready is low, o_tdata and o_tlast hold stable.
  - o_tvalid never drops without a transfer.
- **Simultaneous events**
  - A FIFO write and pop in the same cycle is legal, including when the FIFO is full: the pop frees space first, so the write is accepted and the level is unchanged.
  - A write to an empty FIFO is not visible to the pop in the same cycle.

## Timing
- Reset values: o_tvalid 0, o_tdata 0, o_tlast 0, o_overflow 0, o_frame_cnt 0, o_fifo_level 0. FSM returns to IDLE and the FIFO empties.
- Reset mid-frame discards the partial frame. No CRC is emitted for it.
- Latency: with the block idle and the FIFO empty, i_valid sampled at edge k gives o_tvalid high after edge k+2.
- Throughput: one byte per cycle while i_tready is high. There are no bubbles between words, between data and CRC, or between back-to-back frames when the FIFO is non-empty.
- All outputs are registered.

## Structure
- Shared package `framer_pkg`:
  - CRC32_POLY, CRC32_INIT, CRC32_XOROUT constants.
  - FSM state enum {IDLE, DATA, CRC}.
  - FIFO entry struct {last, nbm1[1:0], data[31:0]}.
  - Function crc32_byte(crc, byte).
- Sub-module `sync_fifo`:
  - Parameters: width, depth.
  - First-word-fall-through, with full, empty and level outputs.
  - Pointers one bit wider than the address for the full/empty distinction.
- Top level holds the FSM, byte mux, CRC register and counters.

## Test plan
- Single-frame CRC, 1 word: word 0x31323334, last, last_bytes=3, i_tready=1.
  - Bytes out: 31 32 33 34 A3 E0 E3 9B, o_tlast on 9B.
  - o_frame_cnt becomes 1. The first byte appears 2 cycles after i_valid.
- Multi-word CRC: words 0x31323334, 0x35363738, then 0x39000000 with last and last_bytes=0.
  - Bytes out: "123456789" followed by 26 39 F4 CB.
- Backpressure: same 3-word frame with i_tready toggled pseudo-randomly.
  - Byte sequence is identical to the multi-word case.
  - o_tdata and o_tlast are stable during every stall.
- Overflow: FIFO_DEPTH=4, i_tready=0, 6 back-to-back words.
  - o_fifo_level reaches 4 and o_overflow sets on the 5th word and stays set.
  - After i_tready=1, exactly 4 words' bytes are emitted.
- Back-to-back frames: two 1-word frames written on consecutive cycles.
  - 16 consecutive transfer cycles with no gap.
  - o_tlast on cycles 8 and 16; o_frame_cnt reaches 2.
- Reset mid-frame: assert i_rst after 2 data bytes.
  - All outputs return to their reset values.
  - A fresh frame afterwards produces the correct CRC.

Source files
------------

// File: rtl/framer_pkg.sv
// Shared definitions for the word-to-byte framer: CRC-32 constants, FSM states,
// FIFO entry layout and the byte-wise CRC update.
package framer_pkg;

   localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CRC
   } state_t;

   typedef struct packed {
      logic        last;
      logic [1:0]  nbm1;
      logic [31:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   // Reflected CRC-32: one byte folded in LSB-first, eight unrolled shift steps.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/word_byte_framer_if.sv
// Word stream in (no backpressure) and byte stream out (ready/valid) of the framer.
interface word_byte_framer_if;
   logic [31:0] i_data;
   logic        i_valid;
   logic        i_last;
   logic [1:0]  i_last_bytes;
   logic [7:0]  o_tdata;
   logic        o_tvalid;
   logic        i_tready;
   logic        o_tlast;

   modport master (
      output i_data, i_valid, i_last, i_last_bytes, i_tready,
      input  o_tdata, o_tvalid, o_tlast
   );

   modport slave (
      input  i_data, i_valid, i_last, i_last_bytes, i_tready,
      output o_tdata, o_tvalid, o_tlast
   );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO on a registered-read RAM array;
// a bypass register covers a write landing on the address being fetched.
module sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 512
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_next, level_reg;
   logic [WIDTH-1:0] ram_q_reg, byp_data_reg;
   logic             byp_reg;
   logic             wr_ok, rd_ok;

   assign empty       = (wr_ptr_reg == rd_ptr_reg);
   assign full        = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
   assign rd_ok       = rd_en && !empty;
   // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
   assign wr_ok       = wr_en && (!full || rd_ok);
   assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_ok};
   assign rd_data     = byp_reg ? byp_data_reg : ram_q_reg;
   assign level       = level_reg;

   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
      ram_q_reg <= mem[rd_ptr_next[AW-1:0]];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         byp_reg      <= 1'b0;
         byp_data_reg <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         rd_ptr_reg   <= rd_ptr_next;
         level_reg    <= level_reg + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
         byp_reg      <= wr_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);
         byp_data_reg <= wr_data;
      end
   end
endmodule

// File: rtl/word_byte_framer.sv
// Buffers 32-bit words and serializes them MSB-byte-first onto a ready/valid byte
// stream, closing each frame with a 4-byte CRC-32 trailer (LSB first).
module word_byte_framer
   import framer_pkg::*;
#(
   parameter int FIFO_DEPTH = 512
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   word_byte_framer_if.slave           bus,
   output logic                        o_overflow,
   output logic [15:0]                 o_frame_cnt,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
   fifo_entry_t wr_entry, head;
   logic        full, empty, pop, adv, last_byte;
   logic [7:0]  cur_byte;
   logic [7:0]  lane [4];
   logic [7:0]  crc_lane [4];
   logic [31:0] crc_fin;

   state_t      state_reg;
   logic [1:0]  idx_reg, crc_idx_reg;
   logic [31:0] crc_reg;
   logic [7:0]  tdata_reg;
   logic        tvalid_reg, tlast_reg, overflow_reg;
   logic [15:0] frame_cnt_reg;

   always_comb begin
      wr_entry.last = bus.i_last;
      wr_entry.nbm1 = bus.i_last ? bus.i_last_bytes : 2'd3;
      wr_entry.data = bus.i_data;
   end

   sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (bus.i_valid),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (o_fifo_level)
   );

   assign crc_fin = crc_reg ^ CRC32_XOROUT;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi]     = head.data[31-8*gi -: 8];
      assign crc_lane[gi] = crc_fin[8*gi +: 8];
   end

   // The word under transmission stays at the FIFO head until its final byte
   // enters the output register, so o_fifo_level counts it.
   assign adv       = !tvalid_reg || bus.i_tready;
   assign cur_byte  = lane[idx_reg];
   assign last_byte = (idx_reg == head.nbm1);
   assign pop       = (state_reg == DATA) && !empty && adv && last_byte;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         crc_idx_reg   <= '0;
         crc_reg       <= CRC32_INIT;
         tdata_reg     <= '0;
         tvalid_reg    <= 1'b0;
         tlast_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         if (bus.i_valid && full && !pop) begin
            overflow_reg <= 1'b1;
         end
         if (tvalid_reg && bus.i_tready && tlast_reg) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
         end
         if (adv) begin
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (!empty) begin
                  idx_reg   <= '0;
                  crc_reg   <= CRC32_INIT;
                  state_reg <= DATA;
               end
            end
            DATA: begin
               if (!empty && adv) begin
                  tdata_reg  <= cur_byte;
                  tvalid_reg <= 1'b1;
                  crc_reg    <= crc32_byte(crc_reg, cur_byte);
                  if (last_byte) begin
                     idx_reg <= '0;
                     if (head.last) begin
                        crc_idx_reg <= '0;
                        state_reg   <= CRC;
                     end
                  end else begin
                     idx_reg <= idx_reg + 2'd1;
                  end
               end
            end
            CRC: begin
               if (adv) begin
                  tdata_reg   <= crc_lane[crc_idx_reg];
                  tvalid_reg  <= 1'b1;
                  tlast_reg   <= (crc_idx_reg == 2'd3);
                  crc_idx_reg <= crc_idx_reg + 2'd1;
                  if (crc_idx_reg == 2'd3) begin
                     if (!empty) begin
                        idx_reg   <= '0;
                        crc_reg   <= CRC32_INIT;
                        state_reg <= DATA;
                     end else begin
                        state_reg <= IDLE;
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.o_tdata  = tdata_reg;
   assign bus.o_tvalid = tvalid_reg;
   assign bus.o_tlast  = tlast_reg;
   assign o_overflow   = overflow_reg;
   assign o_frame_cnt  = frame_cnt_reg;
endmodule

// File: tb/tb_word_byte_framer.sv
// Bench for word_byte_framer: directed CRC vectors, backpressure, overflow,
// back-to-back frames, mid-frame reset and randomized frames against a byte-queue model.
module tb_word_byte_framer;
   typedef logic [7:0] bytes_t[$];

   logic        clk;
   logic        rst;
   logic        overflow;
   logic [15:0] frame_cnt;
   logic [2:0]  fifo_level;

   word_byte_framer_if bus();

   word_byte_framer #(.FIFO_DEPTH(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (bus),
      .o_overflow   (overflow),
      .o_frame_cnt  (frame_cnt),
      .o_fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         stall_err = 0;
   int         model_frames = 0;
   bit         rand_ready = 0;
   logic       prev_valid = 0, prev_ready = 0, prev_last = 0;
   logic [7:0] prev_data = 0;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   int         xfer_cyc_q[$];

   function automatic logic [31:0] crc_ref(input bytes_t q);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ q[i][b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      return ~c;
   endfunction

   task automatic model_frame(input logic [31:0] words[$], input logic [1:0] lb);
      bytes_t      bq;
      logic [31:0] c;
      int          nb;
      foreach (words[w]) begin
         nb = (w == words.size() - 1) ? int'(lb) + 1 : 4;
         for (int k = 0; k < nb; k++) bq.push_back(8'(words[w] >> (24 - 8 * k)));
      end
      c = crc_ref(bq);
      foreach (bq[i]) exp_q.push_back({1'b0, bq[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 8'(c >> (8 * k))});
      model_frames++;
   endtask

   task automatic tick();
      if (rand_ready) bus.i_tready = ($urandom_range(0, 1) == 1);
      if (prev_valid && !prev_ready &&
          (bus.o_tvalid !== 1'b1 || bus.o_tdata !== prev_data || bus.o_tlast !== prev_last))
         stall_err++;
      if (bus.o_tvalid === 1'b1 && bus.i_tready) begin
         got_q.push_back({bus.o_tlast, bus.o_tdata});
         xfer_cyc_q.push_back(cyc);
         $display("[%0d] byte %h last %b", cyc, bus.o_tdata, bus.o_tlast);
      end
      prev_valid = bus.o_tvalid;
      prev_ready = bus.i_tready;
      prev_data  = bus.o_tdata;
      prev_last  = bus.o_tlast;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] lb);
      bus.i_data       = d;
      bus.i_valid      = 1'b1;
      bus.i_last       = last;
      bus.i_last_bytes = lb;
      tick();
      bus.i_valid      = 1'b0;
      bus.i_last       = 1'b0;
   endtask

   task automatic do_reset();
      rand_ready   = 0;
      bus.i_tready = 1'b0;
      bus.i_valid  = 1'b0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
      xfer_cyc_q.delete();
      prev_valid   = 0;
      stall_err    = 0;
      model_frames = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (got_q.size() < exp_q.size() && n < 3000) begin
         tick();
         n++;
      end
      if (got_q.size() < exp_q.size()) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d bytes, required %0d", got_q.size(), exp_q.size());
      end
      repeat (12) tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec += 6;
      if (bus.o_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b required 0", bus.o_tvalid); end
      if (bus.o_tdata !== 8'h00) begin n_bad++; $display("FAIL reset_tdata: got %h required 00", bus.o_tdata); end
      if (bus.o_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b required 0", bus.o_tlast); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
      if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
      $display("test_reset done");
   endtask

   task automatic test_single_frame();
      logic [7:0] ref_b [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'hA3, 8'hE0, 8'hE3, 8'h9B};
      int n = 0;
      do_reset();
      bus.i_tready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, ref_b[i]});
      send_word(32'h3132_3334, 1'b1, 2'd3);
      while (bus.o_tvalid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_vec++;
      if (n !== 2) begin n_bad++; $display("FAIL single_latency: got %0d edges, required 2", n); end
      drain();
      n_vec++;
      if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL single_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL single_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      n_vec++;
      if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt); end
      $display("test_single_frame done");
   endtask

   task automatic test_multi_word(input bit bp);
      logic [7:0] ref_b [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                 8'h26, 8'h39, 8'hF4, 8'hCB};
      do_reset();
      rand_ready   = bp;
      bus.i_tready = 1'b1;
      for (int i = 0; i < 13; i++) exp_q.push_back({i == 12, ref_b[i]});
      send_word(32'h3132_3334, 1'b0, 2'd1);
      send_word(32'h3536_3738, 1'b0, 2'd2);
      send_word(32'h3900_0000, 1'b1, 2'd0);
      drain();
      n_vec++;
      if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL multi_count(bp=%0d): got %0d required %0d", bp, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL multi_byte%0d(bp=%0d): got %h required %h", i, bp, got_q[i], exp_q[i]); end
      end
      n_vec++;
      if (stall_err !== 0) begin n_bad++; $display("FAIL multi_stall_stable(bp=%0d): got %0d violations required 0", bp, stall_err); end
      $display("test_multi_word bp=%0d done", bp);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic [31:0] one[$];
      do_reset();
      for (int i = 0; i < 6; i++) begin
         d = $urandom;
         if (i < 4) begin
            one.delete();
            one.push_back(d);
            model_frame(one, 2'd3);
         end
         send_word(d, 1'b1, 2'd3);
         if (i == 3) begin
            n_vec += 2;
            if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d required 4", fifo_level); end
            if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b required 0", overflow); end
         end
         if (i >= 4) begin
            n_vec += 2;
            if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_w%0d: got %b required 1", i + 1, overflow); end
            if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level_w%0d: got %0d required 4", i + 1, fifo_level); end
         end
      end
      bus.i_tready = 1'b1;
      drain();
      n_vec++;
      if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ovf_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      n_vec += 2;
      if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
      if (frame_cnt !== 16'(model_frames)) begin n_bad++; $display("FAIL ovf_frame_cnt: got %0d required %0d", frame_cnt, model_frames); end
      $display("test_overflow done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic [31:0] one[$];
      do_reset();
      bus.i_tready = 1'b1;
      a = $urandom;
      b = $urandom;
      one.push_back(a);
      model_frame(one, 2'd3);
      one.delete();
      one.push_back(b);
      model_frame(one, 2'd3);
      send_word(a, 1'b1, 2'd3);
      send_word(b, 1'b1, 2'd3);
      drain();
      n_vec++;
      if (got_q.size() !== 16) begin n_bad++; $display("FAIL b2b_count: got %0d required 16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         n_vec += 2;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
         if (xfer_cyc_q[i] !== xfer_cyc_q[0] + i) begin n_bad++; $display("FAIL b2b_gap%0d: got cycle %0d required %0d", i, xfer_cyc_q[i], xfer_cyc_q[0] + i); end
      end
      n_vec++;
      if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      logic [31:0] one[$];
      int n = 0;
      do_reset();
      bus.i_tready = 1'b1;
      send_word(32'hDEAD_BEEF, 1'b1, 2'd3);
      while (got_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prev_valid = 0;
      n_vec += 4;
      if (bus.o_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_tvalid: got %b required 0", bus.o_tvalid); end
      if (bus.o_tdata !== 8'h00) begin n_bad++; $display("FAIL mid_tdata: got %h required 00", bus.o_tdata); end
      if (bus.o_tlast !== 1'b0) begin n_bad++; $display("FAIL mid_tlast: got %b required 0", bus.o_tlast); end
      if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL mid_level: got %0d required 0", fifo_level); end
      got_q.delete();
      repeat (12) tick();
      n_vec += 2;
      if (got_q.size() !== 0) begin n_bad++; $display("FAIL mid_no_trailer: got %0d bytes required 0", got_q.size()); end
      if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_frame_cnt: got %0d required 0", frame_cnt); end
      one.push_back(32'h3132_3334);
      model_frame(one, 2'd3);
      send_word(32'h3132_3334, 1'b1, 2'd3);
      drain();
      n_vec++;
      if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL mid_fresh_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_fresh_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      logic [31:0] words[$];
      logic [1:0]  lb;
      int          nw;
      do_reset();
      rand_ready = 1;
      for (int f = 0; f < 40; f++) begin
         words.delete();
         nw = $urandom_range(1, 4);
         lb = 2'($urandom);
         for (int w = 0; w < nw; w++) words.push_back($urandom);
         model_frame(words, lb);
         for (int w = 0; w < nw; w++) begin
            send_word(words[w], w == nw - 1, (w == nw - 1) ? lb : 2'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
         end
         drain();
      end
      n_vec++;
      if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      n_vec += 3;
      if (stall_err !== 0) begin n_bad++; $display("FAIL rand_stall_stable: got %0d violations required 0", stall_err); end
      if (frame_cnt !== 16'(model_frames)) begin n_bad++; $display("FAIL rand_frame_cnt: got %0d required %0d", frame_cnt, model_frames); end
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand_overflow: got %b required 0", overflow); end
      $display("test_random done");
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_data       = '0;
      bus.i_valid      = 1'b0;
      bus.i_last       = 1'b0;
      bus.i_last_bytes = '0;
      bus.i_tready     = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_multi_word(1'b0);
      test_multi_word(1'b1);
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
